vga_timing_gen: RTL and testbench

- Generates 640x480@60Hz VGA raster timing for the pixel-clock domain.
- Drives DrawX/DrawY into the image/sprite ROM pipelines and drives the hs/vs pins.
- Produces the blank (display-enable) qualifier consumed by the colour output registers.
- hs/vs/blank can be delayed by a parameterised number of cycles so they stay aligned with ROM and palette read latency. Also provides a frame-start pulse and a frame counter for animation logic.

---
 rtl/vga_timing_gen.sv | 88 ++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz raster counters, sync/blank decode with a
// configurable alignment delay, plus frame-start pulse and frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_hc, r_vc;
    logic       r_frame_start;
    logic [7:0] r_frame_count;
    logic       w_h_end, w_v_end;
    logic [2:0] w_raw;

    assign w_h_end = r_hc == H_LAST;
    assign w_v_end = r_vc == V_LAST;
    assign w_raw   = {!(r_hc >= HS_BEG && r_hc < HS_END),
                      !(r_vc >= VS_BEG && r_vc < VS_END),
                      r_hc < H_VIS && r_vc < V_VIS};

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hc          <= w_h_end ? '0 : r_hc + 10'd1;
            if (w_h_end)
                r_vc      <= w_v_end ? '0 : r_vc + 10'd1;
            // registered so the pulse lands on the (0,0) cycle after the wrap
            r_frame_start <= w_h_end && w_v_end;
            if (w_h_end && w_v_end)
                r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

    if (SYNC_DELAY == 0) begin : g_nodly
        // reset forces the idle levels even though there is no register stage
        assign hs    = w_raw[2] | ~reset_n;
        assign vs    = w_raw[1] | ~reset_n;
        assign blank = w_raw[0] & reset_n;
    end else begin : g_dly
        logic [2:0] r_pipe [SYNC_DELAY];
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < SYNC_DELAY; i++)
                    r_pipe[i] <= 3'b110;
            end else begin
                r_pipe[0] <= w_raw;
                for (int i = 1; i < SYNC_DELAY; i++)
                    r_pipe[i] <= r_pipe[i-1];
            end
        end
        assign {hs, vs, blank} = r_pipe[SYNC_DELAY-1];
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default (delay 2), zero-delay and
// shrunken-raster instances sharing one clock and reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, z_x, z_y, s_x, s_y;
    logic       a_hs, a_vs, a_bl, a_fs, z_hs, z_vs, z_bl, z_fs, s_hs, s_vs, s_bl, s_fs;
    logic [7:0] a_fc, z_fc, s_fc;

    vga_timing_gen u_a (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(a_x), .DrawY(a_y), .hs(a_hs), .vs(a_vs),
        .blank(a_bl), .frame_start(a_fs), .frame_count(a_fc));

    vga_timing_gen #(.SYNC_DELAY(0)) u_z (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(z_x), .DrawY(z_y), .hs(z_hs), .vs(z_vs),
        .blank(z_bl), .frame_start(z_fs), .frame_count(z_fc));

    // 15 clocks per line, 8 lines per frame -> 120 clocks per frame
    vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                     .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .SYNC_DELAY(2)) u_s (
        .vga_clk(clk), .reset_n(rst_n), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
        .blank(s_bl), .frame_start(s_fs), .frame_count(s_fc));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int a_bcnt = 0, a_bfirst = -1, a_hcnt = 0, a_hfirst = -1, a_vcnt = 0;
    int z_bcnt = 0, z_bfirst = -1, z_blast = -1, z_hcnt = 0, z_hfirst = -1, z_hlast = -1;
    int s_vcnt = 0, s_vfx = -1, s_vfy = -1, s_bcnt = 0, s_bbad = 0;
    int fs_cnt = 0, fs_bad = 0;
    logic fs_prev = 1'b0;

    initial begin
        repeat (3) step();
        chk("rst_drawx", int'(a_x), 0);
        chk("rst_drawy", int'(a_y), 0);
        chk("rst_hs", int'(a_hs), 1);
        chk("rst_vs", int'(a_vs), 1);
        chk("rst_blank", int'(a_bl), 0);
        chk("rst_fs", int'(a_fs), 0);
        chk("rst_fc", int'(a_fc), 0);
        chk("rst_blank_d0", int'(z_bl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int n = 0; n <= 30905; n++) begin
            if (n > 0) step();
            if (n < 800) begin
                if (a_bl) begin a_bcnt++; if (a_bfirst < 0) a_bfirst = int'(a_x); end
                if (!a_hs) begin a_hcnt++; if (a_hfirst < 0) a_hfirst = int'(a_x); end
                if (!a_vs) a_vcnt++;
                if (z_bl) begin z_bcnt++; z_blast = int'(z_x); if (z_bfirst < 0) z_bfirst = int'(z_x); end
                if (!z_hs) begin z_hcnt++; z_hlast = int'(z_x); if (z_hfirst < 0) z_hfirst = int'(z_x); end
            end
            if (n < 120) begin
                if (!s_vs) begin s_vcnt++; if (s_vfx < 0) begin s_vfx = int'(s_x); s_vfy = int'(s_y); end end
                if (s_bl) begin s_bcnt++; if (s_y >= 10'd4) s_bbad++; end
            end
            if (s_fs) begin
                fs_cnt++;
                if (s_x != 10'd0 || s_y != 10'd0 || fs_prev) fs_bad++;
            end
            fs_prev = s_fs;
            if (n == 0) begin
                chk("rel_blank_d2", int'(a_bl), 0);
                chk("rel_blank_d0", int'(z_bl), 1);
                chk("rel_fs", int'(s_fs), 0);
            end
            if (n == 3) chk("count_x3", int'(a_x), 3);
            if (n == 799) begin
                chk("x_799", int'(a_x), 799);
                chk("y_before_wrap", int'(a_y), 0);
            end
            if (n == 800) begin
                chk("x_wrap", int'(a_x), 0);
                chk("y_wrap", int'(a_y), 1);
                chk("blank_cnt_d2", a_bcnt, 640);
                chk("blank_first_d2", a_bfirst, 2);
                chk("hs_cnt_d2", a_hcnt, 96);
                chk("hs_first_d2", a_hfirst, 658);
                chk("vs_line0_d2", a_vcnt, 0);
                chk("blank_cnt_d0", z_bcnt, 640);
                chk("blank_first_d0", z_bfirst, 0);
                chk("blank_last_d0", z_blast, 639);
                chk("hs_cnt_d0", z_hcnt, 96);
                chk("hs_first_d0", z_hfirst, 656);
                chk("hs_last_d0", z_hlast, 751);
            end
            if (n == 1600) begin
                chk("line2_x", int'(a_x), 0);
                chk("line2_y", int'(a_y), 2);
            end
            if (n == 120) begin
                chk("s_vs_cnt", s_vcnt, 30);
                chk("s_vs_first_x", s_vfx, 2);
                chk("s_vs_first_y", s_vfy, 5);
                chk("s_blank_cnt", s_bcnt, 32);
                chk("s_blank_vblank", s_bbad, 0);
                chk("s_fs_first", int'(s_fs), 1);
                chk("s_fc_first", int'(s_fc), 1);
            end
            if (n == 360) begin
                chk("fs_cnt_3", fs_cnt, 3);
                chk("fc_3", int'(s_fc), 3);
            end
            if (n == 30600) chk("fc_255", int'(s_fc), 255);
            if (n == 30720) begin
                chk("fc_wrap", int'(s_fc), 0);
                chk("fs_cnt_256", fs_cnt, 256);
                chk("fs_bad", fs_bad, 0);
            end
        end
        chk("pre_rst_x", int'(a_x), 505);
        chk("pre_rst_blank", int'(a_bl), 1);
        chk("pre_rst_fc", int'(s_fc), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_x", int'(a_x), 0);
        chk("mid_y", int'(a_y), 0);
        chk("mid_hs", int'(a_hs), 1);
        chk("mid_vs", int'(a_vs), 1);
        chk("mid_blank", int'(a_bl), 0);
        chk("mid_fc", int'(s_fc), 0);
        chk("mid_sx", int'(s_x), 0);
        chk("mid_blank_d0", int'(z_bl), 0);
        step();
        chk("hold_x", int'(a_x), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("re_x1", int'(a_x), 1);
        chk("re_blank1", int'(a_bl), 0);
        step();
        chk("re_x2", int'(a_x), 2);
        chk("re_y2", int'(a_y), 0);
        chk("re_blank2", int'(a_bl), 1);
        repeat (118) step();
        chk("re_s_fs", int'(s_fs), 1);
        chk("re_s_fc", int'(s_fc), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
